// File: rtl/pdd_pkg.sv
// Shared definitions for the priority demux dispatcher.
//   Lane index constants, the FSM state encoding and the sel-to-lane decode function.
package pdd_pkg;

   localparam int unsigned NLANES = 5;

   localparam logic [2:0] LANE0     = 3'd0;
   localparam logic [2:0] LANE1     = 3'd1;
   localparam logic [2:0] LANE2     = 3'd2;
   localparam logic [2:0] LANE3     = 3'd3;
   localparam logic [2:0] LANE_DFLT = 3'd4;

   localparam logic S_EMPTY = 1'b0;
   localparam logic S_FULL  = 1'b1;

   typedef enum logic {
      StEmpty = S_EMPTY,
      StFull  = S_FULL
   } state_e;

   // sel==0 goes to the default lane; otherwise pick the highest (prio_msb=1)
   // or lowest (prio_msb=0) set bit.
   function automatic logic [2:0] sel2lane(input logic [3:0] sel, input logic prio_msb);
      logic [2:0] lane;
      lane = LANE_DFLT;
      if (prio_msb) begin
         for (int i = 0; i < 4; i++) begin
            if (sel[i]) lane = 3'(i);
         end
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (sel[i]) lane = 3'(i);
         end
      end
      return lane;
   endfunction

endpackage

// File: rtl/pdd_lane_counter.sv
// Per-lane dispatch counter.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one completed transfer
//   clr        : synchronous clear, wins over inc
//   cnt        : current count, wraps modulo 2^CW
module pdd_lane_counter #(
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/priority_demux_dispatch.sv
// Routes a single valid/ready item stream to one of five lanes selected by a
// priority decode of a 4-bit mask (lane 4 when the mask is empty). One register stage.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : producer handshake
//   in_data, in_sel     : payload and destination mask
//   out_valid[4:0]      : one-hot pending lane
//   out_ready[4:0]      : per-lane consumer ready (only the pending lane is observed)
//   out_data            : payload shared by all lanes
//   cnt_clr             : synchronous clear of all lane counters
//   lane_cnt            : packed per-lane completed-transfer counts, lane k at [k*CW +: CW]
module priority_demux_dispatch
   import pdd_pkg::*;
#(
   parameter int unsigned DW       = 8,
   parameter int unsigned PRIO_MSB = 1,
   parameter int unsigned CW       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DW-1:0]      in_data,
   input  logic [3:0]         in_sel,
   output logic [NLANES-1:0]  out_valid,
   input  logic [NLANES-1:0]  out_ready,
   output logic [DW-1:0]      out_data,
   input  logic               cnt_clr,
   output logic [NLANES*CW-1:0] lane_cnt
);

   state_e        state_q, state_d;
   logic [2:0]    lane_q, lane_d;
   logic [DW-1:0] data_q, data_d;
   logic          xfer;
   logic          accept;

   // Only the pending lane's ready matters; lane_q is always 0..4.
   assign xfer     = (state_q == StFull) && out_ready[lane_q];
   assign in_ready = (state_q == StEmpty) || out_ready[lane_q];
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      data_d  = data_q;
      unique case (state_q)
         StEmpty: begin
            if (in_valid) begin
               state_d = StFull;
               lane_d  = sel2lane(in_sel, PRIO_MSB != 0);
               data_d  = in_data;
            end
         end
         StFull: begin
            if (xfer) begin
               if (in_valid) begin
                  // Reload in the transfer cycle for full throughput.
                  lane_d = sel2lane(in_sel, PRIO_MSB != 0);
                  data_d = in_data;
               end else begin
                  state_d = StEmpty;
               end
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         lane_q  <= LANE_DFLT;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      out_valid = '0;
      if (state_q == StFull) out_valid[lane_q] = 1'b1;
   end

   assign out_data = data_q;

   for (genvar k = 0; k < NLANES; k++) begin : g_cnt
      logic inc_k;
      assign inc_k = xfer && (lane_q == 3'(k));
      pdd_lane_counter #(
         .CW (CW)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (inc_k),
         .clr   (cnt_clr),
         .cnt   (lane_cnt[k*CW +: CW])
      );
   end

   // accept is consumed implicitly by the FSM; keep it visible for debug.
   logic unused_accept;
   assign unused_accept = accept;

endmodule

// File: tb/tb_priority_demux_dispatch.sv
module tb_priority_demux_dispatch;

   localparam int DW = 8;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [3:0]    in_sel;
   logic [4:0]    out_ready;
   logic          cnt_clr;

   logic          in_ready, in_ready_l;
   logic [4:0]    out_valid, out_valid_l;
   logic [DW-1:0] out_data, out_data_l;
   logic [5*CW-1:0] lane_cnt, lane_cnt_l;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   priority_demux_dispatch #(.DW(DW), .PRIO_MSB(1), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cnt_clr   (cnt_clr),
      .lane_cnt  (lane_cnt)
   );

   priority_demux_dispatch #(.DW(DW), .PRIO_MSB(0), .CW(CW)) dut_l (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_l),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid_l),
      .out_ready (out_ready),
      .out_data  (out_data_l),
      .cnt_clr   (cnt_clr),
      .lane_cnt  (lane_cnt_l)
   );

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand-computed table for the back-to-back stream: lanes 0,1,2,3,4,0,1,2.
   logic [3:0] s_sel  [8];
   logic [4:0] s_oh   [8];

   initial begin
      s_sel[0] = 4'b0001; s_oh[0] = 5'b00001;
      s_sel[1] = 4'b0011; s_oh[1] = 5'b00010;
      s_sel[2] = 4'b0110; s_oh[2] = 5'b00100;
      s_sel[3] = 4'b1111; s_oh[3] = 5'b01000;
      s_sel[4] = 4'b0000; s_oh[4] = 5'b10000;
      s_sel[5] = 4'b0001; s_oh[5] = 5'b00001;
      s_sel[6] = 4'b0010; s_oh[6] = 5'b00010;
      s_sel[7] = 4'b0100; s_oh[7] = 5'b00100;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
      out_ready = 5'b11111; cnt_clr = 1'b0;

      // 1. reset state and default lane
      tick(); tick();
      chk("rst_out_valid", 80'(out_valid), 80'(5'b00000));
      chk("rst_out_data",  80'(out_data),  80'(8'h00));
      chk("rst_lane_cnt",  80'(lane_cnt),  80'(0));
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1; in_sel = 4'b0000; in_data = 8'hA5;
      #1 chk("t1_in_ready", 80'(in_ready), 80'(1'b1));
      tick();
      in_valid = 1'b0;
      #1;
      chk("t1_out_valid", 80'(out_valid), 80'(5'b10000));
      chk("t1_out_data",  80'(out_data),  80'(8'hA5));
      tick();
      chk("t1_cnt4", 80'(lane_cnt[4*CW +: CW]), 80'(16'd1));
      chk("t1_empty", 80'(out_valid), 80'(5'b00000));

      // 2. priority direction
      out_ready = 5'b00000;
      in_valid = 1'b1; in_sel = 4'b0101; in_data = 8'h3C;
      tick();
      in_valid = 1'b0;
      #1;
      chk("t2_msb",  80'(out_valid),   80'(5'b00100));
      chk("t2_lsb",  80'(out_valid_l), 80'(5'b00001));
      out_ready = 5'b11111;
      tick();

      // 3. stall on lane 1 with a new item waiting
      out_ready = 5'b00000;
      in_valid = 1'b1; in_sel = 4'b0010; in_data = 8'h11;
      tick();
      in_sel = 4'b1000; in_data = 8'h22;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_stall_ready", 80'(in_ready),  80'(1'b0));
         chk("t3_stall_data",  80'(out_data),  80'(8'h11));
         chk("t3_stall_valid", 80'(out_valid), 80'(5'b00010));
         tick();
      end
      out_ready = 5'b00010;
      #1 chk("t3_ready_up", 80'(in_ready), 80'(1'b1));
      tick();
      in_valid = 1'b0;
      #1;
      chk("t3_new_valid", 80'(out_valid), 80'(5'b01000));
      chk("t3_new_data",  80'(out_data),  80'(8'h22));
      out_ready = 5'b11111;
      tick();

      // 4. back-to-back stream from cleared counters
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_sel = s_sel[i]; in_data = 8'(8'h40 + i);
         #1;
         chk("t4_in_ready", 80'(in_ready), 80'(1'b1));
         if (i > 0) begin
            chk("t4_valid", 80'(out_valid), 80'(s_oh[i-1]));
            chk("t4_data",  80'(out_data),  80'(8'(8'h40 + i - 1)));
         end
         tick();
      end
      in_valid = 1'b0;
      #1 chk("t4_last", 80'(out_valid), 80'(s_oh[7]));
      tick();
      chk("t4_counts", 80'(lane_cnt), 80'({16'd1, 16'd1, 16'd2, 16'd2, 16'd2}));

      // 5. wrap of lane 3, then clear beating an increment
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      in_valid = 1'b1; in_sel = 4'b1000; in_data = 8'h5A;
      for (int i = 0; i < 65535; i++) tick();
      in_valid = 1'b0;
      tick();
      chk("t5_ffff", 80'(lane_cnt[3*CW +: CW]), 80'(16'hFFFF));
      in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
      chk("t5_wrap", 80'(lane_cnt[3*CW +: CW]), 80'(16'h0000));
      in_valid = 1'b1; in_sel = 4'b0001; tick(); in_valid = 1'b0;
      cnt_clr = 1'b1;
      #1 chk("t5_pend0", 80'(out_valid), 80'(5'b00001));
      tick();
      cnt_clr = 1'b0;
      chk("t5_clr_wins", 80'(lane_cnt[0 +: CW]), 80'(16'h0000));
      chk("t5_drained",  80'(out_valid), 80'(5'b00000));

      // 6. async reset while an item is stalled
      in_valid = 1'b1; in_sel = 4'b0100; in_data = 8'h77; out_ready = 5'b00000;
      tick();
      in_valid = 1'b0;
      #1 chk("t6_pend", 80'(out_valid), 80'(5'b00100));
      #1 rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 80'(out_valid), 80'(5'b00000));
      chk("t6_async_cnt",   80'(lane_cnt),  80'(0));
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_in_ready",  80'(in_ready),  80'(1'b1));
      chk("t6_out_valid", 80'(out_valid), 80'(5'b00000));
      chk("t6_out_data",  80'(out_data),  80'(8'h00));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
